// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] INSTR_NOP = 32'h0000_0013;
  localparam logic [XLEN-1:0] PC_STEP = 32'd4;
  // Wide enough for stale responses accumulated over back-to-back redirects.
  localparam int unsigned DROP_W = 8;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
    logic            filled;
  } fetch_slot_t;

endpackage

// File: rtl/fetch_queue.sv
// In-order slot ring for fetch: slots are allocated on request accept, filled on response and
// popped by decode. Depth must be a power of two so pointers wrap naturally.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned Depth = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   flush_i,
  input  logic                   alloc_i,
  input  logic [XLEN-1:0]        alloc_pc_i,
  input  logic                   fill_i,
  input  logic [XLEN-1:0]        fill_instr_i,
  input  logic                   pop_i,
  output fetch_slot_t            head_o,
  output logic [$clog2(Depth):0] count_o,
  output logic [$clog2(Depth):0] pend_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  fetch_slot_t     slots_q [Depth];
  fetch_slot_t     slots_d [Depth];
  logic [PtrW-1:0] head_q, head_d;
  logic [PtrW-1:0] fill_q, fill_d;
  logic [PtrW-1:0] tail_q, tail_d;
  logic [CntW-1:0] count_q, count_d;
  logic [CntW-1:0] pend_q, pend_d;

  always_comb begin
    slots_d = slots_q;
    head_d  = head_q;
    fill_d  = fill_q;
    tail_d  = tail_q;
    count_d = count_q;
    pend_d  = pend_q;
    if (flush_i) begin
      for (int i = 0; i < Depth; i++) begin
        slots_d[i].filled = 1'b0;
      end
      head_d  = '0;
      fill_d  = '0;
      tail_d  = '0;
      count_d = '0;
      pend_d  = '0;
    end else begin
      if (alloc_i) begin
        slots_d[tail_q].pc     = alloc_pc_i;
        slots_d[tail_q].instr  = INSTR_NOP;
        slots_d[tail_q].filled = 1'b0;
        tail_d                 = tail_q + PtrW'(1);
      end
      if (fill_i) begin
        slots_d[fill_q].instr  = fill_instr_i;
        slots_d[fill_q].filled = 1'b1;
        fill_d                 = fill_q + PtrW'(1);
      end
      // Pop after fill: a bypassed fill+pop of the head slot leaves it unfilled.
      if (pop_i) begin
        slots_d[head_q].filled = 1'b0;
        head_d                 = head_q + PtrW'(1);
      end
      count_d = count_q + CntW'(alloc_i) - CntW'(pop_i);
      pend_d  = pend_q + CntW'(alloc_i) - CntW'(fill_i);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < Depth; i++) begin
        slots_q[i] <= '0;
      end
      head_q  <= '0;
      fill_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      pend_q  <= '0;
    end else begin
      slots_q <= slots_d;
      head_q  <= head_d;
      fill_q  <= fill_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      pend_q  <= pend_d;
    end
  end

  assign head_o  = slots_q[head_q];
  assign count_o = count_q;
  assign pend_o  = pend_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues word fetches and feeds decode in order.
// Define FETCH_BYPASS_EN to forward a response straight to decode when the ring has nothing ready.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned QUEUE_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc
);

  localparam int unsigned CntW = $clog2(QUEUE_DEPTH) + 1;

  logic [XLEN-1:0]   pc_q, pc_d;
  logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;
  logic              req_fire;
  logic              rsp_drop;
  logic              rsp_accept;
  logic              bypass;
  logic              pop;
  fetch_slot_t       head;
  logic [CntW-1:0]   count;
  logic [CntW-1:0]   pend;

  fetch_queue #(
    .Depth (QUEUE_DEPTH)
  ) u_queue (
    .clk_i        (clk),
    .rst_ni       (rst),
    .flush_i      (redirect_valid),
    .alloc_i      (req_fire),
    .alloc_pc_i   (pc_q),
    .fill_i       (rsp_accept),
    .fill_instr_i (imem_rsp_data),
    .pop_i        (pop),
    .head_o       (head),
    .count_o      (count),
    .pend_o       (pend)
  );

  // Held low while in reset; a full ring issues nothing even if decode pops this cycle.
  assign imem_req_valid = rst & (count < CntW'(QUEUE_DEPTH)) & ~redirect_valid;
  assign imem_req_addr  = pc_q;

  always_comb begin
    req_fire   = imem_req_valid & imem_req_ready;
    rsp_drop   = imem_rsp_valid & (drop_cnt_q != '0);
    rsp_accept = imem_rsp_valid & ~rsp_drop & ~redirect_valid;
`ifdef FETCH_BYPASS_EN
    bypass     = rsp_accept & ~head.filled & (pend != '0);
    out_valid  = head.filled | bypass;
    out_instr  = head.filled ? head.instr : imem_rsp_data;
`else
    bypass     = 1'b0;
    out_valid  = head.filled;
    out_instr  = head.instr;
`endif
    out_pc     = head.pc;
    pop        = out_valid & out_ready;
  end

  always_comb begin
    pc_d       = pc_q;
    drop_cnt_d = drop_cnt_q;
    if (redirect_valid) begin
      pc_d       = redirect_pc & ~32'h3;
      // Every unfilled slot still has a response on its way; one arriving now is consumed here.
      drop_cnt_d = drop_cnt_q + DROP_W'(pend) - DROP_W'(imem_rsp_valid);
    end else begin
      if (req_fire) begin
        pc_d = pc_q + PC_STEP;
      end
      if (rsp_drop) begin
        drop_cnt_d = drop_cnt_q - DROP_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q       <= RESET_PC;
      drop_cnt_q <= '0;
    end else begin
      pc_q       <= pc_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit against a transaction-level model of PC stream and memory.
module tb_fetch_unit;

  localparam int unsigned Depth   = 4;
  localparam logic [31:0] ResetPc = 32'h0000_0000;
`ifdef FETCH_BYPASS_EN
  localparam bit Bypass = 1'b1;
`else
  localparam bit Bypass = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;

  fetch_unit #(
    .RESET_PC    (ResetPc),
    .QUEUE_DEPTH (Depth)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [31:0] addr;
    int          ep;
    int          due;
  } req_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } out_t;

  req_t        inflight[$];
  out_t        avail[$];
  logic [31:0] mpc;
  int          ep;
  int          used;
  int          cyc;
  int          last_due;
  int          lat;
  int          n_cmp;
  int          n_err;
  int          hs_cnt;
  logic        prev_top;
  logic        saw_wrap;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h1357_2468;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  task automatic do_reset(input int n);
    rst            = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    out_ready      = 1'b0;
    inflight.delete();
    avail.delete();
    used     = 0;
    mpc      = ResetPc;
    last_due = 0;
    ep++;
    #4;
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_req_valid", 32'(imem_req_valid), 32'd0);
    check_eq("rst_out_pc", out_pc, 32'd0);
    check_eq("rst_out_instr", out_instr, 32'd0);
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b1;
    cyc++;
  endtask

  // One clock: drive inputs just after the edge, check mid-cycle, advance the model.
  task automatic step(input logic redir, input logic [31:0] tgt, input logic rq_rdy,
                      input logic o_rdy);
    logic        rsp_v;
    logic [31:0] rsp_pc;
    int          rsp_ep;
    logic        fresh;
    logic        exp_ov;
    logic        exp_rv;
    out_t        o;
    req_t        r;
    int          due;
    redirect_valid = redir;
    redirect_pc    = tgt;
    imem_req_ready = rq_rdy;
    out_ready      = o_rdy;
    rsp_v          = 1'b0;
    rsp_pc         = '0;
    rsp_ep         = -1;
    if (inflight.size() > 0 && inflight[0].due <= cyc) begin
      r      = inflight.pop_front();
      rsp_v  = 1'b1;
      rsp_pc = r.addr;
      rsp_ep = r.ep;
    end
    imem_rsp_valid = rsp_v;
    imem_rsp_data  = rsp_v ? mem_word(rsp_pc) : $urandom;
    #4;
    fresh  = rsp_v && (rsp_ep == ep) && !redir;
    exp_ov = (avail.size() > 0) || (Bypass && fresh);
    check_eq("out_valid", 32'(out_valid), 32'(exp_ov));
    if (exp_ov) begin
      if (avail.size() > 0) begin
        o = avail[0];
      end else begin
        o.pc    = rsp_pc;
        o.instr = mem_word(rsp_pc);
      end
      check_eq("out_pc", out_pc, o.pc);
      check_eq("out_instr", out_instr, o.instr);
    end
    exp_rv = (used < int'(Depth)) && !redir;
    check_eq("req_valid", 32'(imem_req_valid), 32'(exp_rv));
    if (exp_rv) check_eq("req_addr", imem_req_addr, mpc);
    if (imem_req_valid && imem_req_ready) begin
      hs_cnt++;
      if (imem_req_addr == 32'h0 && prev_top) saw_wrap = 1'b1;
      prev_top = (imem_req_addr == 32'hFFFF_FFFC);
    end
    if (redir) begin
      mpc  = tgt & ~32'h3;
      ep++;
      avail.delete();
      used = 0;
    end else begin
      if (exp_rv && rq_rdy) begin
        due = cyc + lat;
        if (due <= last_due) due = last_due + 1;
        last_due = due;
        r.addr   = mpc;
        r.ep     = ep;
        r.due    = due;
        inflight.push_back(r);
        used++;
        mpc = mpc + 32'd4;
      end
      if (fresh) begin
        o.pc    = rsp_pc;
        o.instr = mem_word(rsp_pc);
        avail.push_back(o);
      end
      if (exp_ov && o_rdy) begin
        avail.delete(0);
        used--;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    n_cmp    = 0;
    n_err    = 0;
    cyc      = 0;
    ep       = 0;
    lat      = 1;
    hs_cnt   = 0;
    prev_top = 1'b0;
    saw_wrap = 1'b0;
    rst      = 1'b1;
    @(posedge clk);
    #1;
    do_reset(3);

    // Streaming with a one-cycle memory.
    for (int i = 0; i < 30; i++) step(1'b0, 32'h0, 1'b1, 1'b1);

    // Decode stalled: exactly Depth requests accepted after the ring is cleared.
    step(1'b1, 32'h200, 1'b1, 1'b1);
    hs_cnt = 0;
    for (int i = 0; i < 12; i++) step(1'b0, 32'h0, 1'b1, 1'b0);
    check_eq("full_handshakes", 32'(hs_cnt), 32'd4);
    for (int i = 0; i < 8; i++) step(1'b0, 32'h0, 1'b1, 1'b1);

    // Redirect with responses in flight.
    lat = 3;
    for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b1, 1'b1);
    step(1'b1, 32'h103, 1'b1, 1'b1);
    for (int i = 0; i < 12; i++) step(1'b0, 32'h0, 1'b1, 1'b1);

    // Random traffic, redirects and latencies.
    for (int i = 0; i < 300; i++) begin
      logic        rd;
      logic [31:0] tg;
      lat = $urandom_range(1, 3);
      rd  = ($urandom_range(0, 11) == 0);
      tg  = ($urandom_range(0, 3) == 0) ? 32'h103 : $urandom;
      step(rd, tg, ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0));
    end

    // Reset in the middle of traffic.
    do_reset(2);
    lat = 2;
    for (int i = 0; i < 20; i++) step(1'b0, 32'h0, 1'b1, 1'b1);

    // PC wrap with toggling request ready and slow memory.
    lat      = 3;
    saw_wrap = 1'b0;
    prev_top = 1'b0;
    step(1'b1, 32'hFFFF_FFF0, 1'b1, 1'b1);
    for (int i = 0; i < 24; i++) step(1'b0, 32'h0, (i % 2 == 0), 1'b1);
    check_eq("pc_wrap", 32'(saw_wrap), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
